// File: rtl/dram_ctrl_pkg.sv
// Shared types and defaults for the DRAM controller: state encoding,
// default widths/latency and the latency counter width.
package dram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_LATENCY = 2;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/dram_lat_cnt.sv
// Strobe latency down-counter: loads on accept, decrements while waiting,
// flags zero so the controller knows the next edge completes the access.
module dram_lat_cnt
    import dram_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dram_ctrl.sv
// Single-outstanding DRAM access controller holding RD/WR strobes for LATENCY
// cycles. Define DRAM_CTRL_POSTED_WR_EN to acknowledge writes right after accept.
module dram_ctrl
    import dram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic [DATA_W-1:0] o_mem_data_out,
    input  logic [DATA_W-1:0] i_mem_data_in
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_t            r_state, w_next;
    logic              w_accept, w_done, w_dec, w_zero;
    logic [CNT_W-1:0]  w_cnt;
    logic              r_ack;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_dout, r_rdata;

    dram_lat_cnt u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_accept),
        .i_load_val (LOAD_VAL),
        .i_dec      (w_dec),
        .o_cnt      (w_cnt),
        .o_zero     (w_zero)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        w_dec    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_req) begin
                    w_accept = 1'b1;
                    w_next   = i_we ? WR_WAIT : RD_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (w_zero) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Address/data are latched once at accept so they stay stable for the whole strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ack      <= 1'b0;
            r_mem_addr <= '0;
            r_mem_dout <= '0;
            r_rdata    <= '0;
        end else begin
            r_ack <= 1'b0;
            if (w_accept) begin
                r_mem_addr <= i_addr;
                r_mem_dout <= i_wdata;
`ifdef DRAM_CTRL_POSTED_WR_EN
                r_ack      <= i_we;
`endif
            end
            if (w_done) begin
`ifdef DRAM_CTRL_POSTED_WR_EN
                r_ack <= (r_state == RD_WAIT);
`else
                r_ack <= 1'b1;
`endif
                if (r_state == RD_WAIT)
                    r_rdata <= i_mem_data_in;
            end
        end
    end

    assign o_ack          = r_ack;
    assign o_rdata        = r_rdata;
    assign o_busy         = (r_state != IDLE);
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_rd       = (r_state == RD_WAIT);
    assign o_mem_wr       = (r_state == WR_WAIT);
    assign o_mem_data_out = r_mem_dout;

    // Keeps the counter value observable for debug without a dangling net.
    logic w_cnt_unused;
    assign w_cnt_unused = ^w_cnt;

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl: LATENCY 1, 2 and 15 instances share stimulus;
// write-ack expectations follow DRAM_CTRL_POSTED_WR_EN.
module tb_dram_ctrl;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [15:0] addr, wdata, mem_din;

    logic [2:0]  ack, busy, mem_rd, mem_wr;
    logic [15:0] rdata    [3];
    logic [15:0] mem_addr [3];
    logic [15:0] mem_dout [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dram_ctrl #(.LATENCY(1)) u_l1 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ack(ack[0]), .o_rdata(rdata[0]), .o_busy(busy[0]), .o_mem_addr(mem_addr[0]),
        .o_mem_rd(mem_rd[0]), .o_mem_wr(mem_wr[0]), .o_mem_data_out(mem_dout[0]),
        .i_mem_data_in(mem_din)
    );

    dram_ctrl #(.LATENCY(2)) u_l2 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ack(ack[1]), .o_rdata(rdata[1]), .o_busy(busy[1]), .o_mem_addr(mem_addr[1]),
        .o_mem_rd(mem_rd[1]), .o_mem_wr(mem_wr[1]), .o_mem_data_out(mem_dout[1]),
        .i_mem_data_in(mem_din)
    );

    dram_ctrl #(.LATENCY(15)) u_l15 (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .o_ack(ack[2]), .o_rdata(rdata[2]), .o_busy(busy[2]), .o_mem_addr(mem_addr[2]),
        .o_mem_rd(mem_rd[2]), .o_mem_wr(mem_wr[2]), .o_mem_data_out(mem_dout[2]),
        .i_mem_data_in(mem_din)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on instance k; strobe width, stability, ack count and rdata.
    task automatic do_op(input int k, input int lat, input logic w,
                         input logic [15:0] a, input logic [15:0] d, input logic [15:0] din);
        int   n;
        int   acks;
        logic posted;
        posted = 1'b0;
`ifdef DRAM_CTRL_POSTED_WR_EN
        posted = w;
`endif
        req = 1'b1; we = w; addr = a; wdata = d; mem_din = ~din;
        tick();
        req = 1'b0; addr = 16'hFFFF; wdata = 16'h0000;
        n = 0;
        acks = 0;
        while (((w ? mem_wr[k] : mem_rd[k]) === 1'b1) && n < 40) begin
            n++;
            chk("busy_strobe", {31'd0, busy[k]}, 32'd1);
            chk("other_strobe", {31'd0, (w ? mem_rd[k] : mem_wr[k])}, 32'd0);
            chk("mem_addr", {16'd0, mem_addr[k]}, {16'd0, a});
            if (w) chk("mem_dout", {16'd0, mem_dout[k]}, {16'd0, d});
            chk("ack_strobe", {31'd0, ack[k]}, {31'd0, (posted && n == 1)});
            acks += int'(ack[k]);
            mem_din = (n == lat) ? din : ~din;
            tick();
        end
        chk("strobe_len", n, lat);
        chk("ack_done", {31'd0, ack[k]}, {31'd0, !posted});
        acks += int'(ack[k]);
        chk("busy_done", {31'd0, busy[k]}, 32'd0);
        if (!w) chk("rdata", {16'd0, rdata[k]}, {16'd0, din});
        tick();
        chk("ack_count", acks, 1);
        chk("ack_clear", {31'd0, ack[k]}, 32'd0);
        if (!w) chk("rdata_hold", {16'd0, rdata[k]}, {16'd0, din});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; mem_din = '0;
        #2;
        chk("rst_ack",   {29'd0, ack},    32'd0);
        chk("rst_busy",  {29'd0, busy},   32'd0);
        chk("rst_rd",    {29'd0, mem_rd}, 32'd0);
        chk("rst_wr",    {29'd0, mem_wr}, 32'd0);
        chk("rst_addr",  {16'd0, mem_addr[1]}, 32'd0);
        chk("rst_dout",  {16'd0, mem_dout[1]}, 32'd0);
        chk("rst_rdata", {16'd0, rdata[1]},    32'd0);
        tick();
        rst = 1'b0;

        // LATENCY=2 read and write
        do_op(1, 2, 1'b0, 16'h0040, 16'h0000, 16'hBEEF);
        do_op(1, 2, 1'b1, 16'h1234, 16'hA5A5, 16'h0000);
        chk("wr_keeps_rdata", {16'd0, rdata[1]}, 32'h0000BEEF);

        // Held Req: second accept at E3, Req during E1 ignored
        repeat (20) tick();
        mem_din = 16'h1111;
        req = 1'b1; we = 1'b0; addr = 16'h0040;
        tick();
        chk("b2b_e0_rd", {31'd0, mem_rd[1]}, 32'd1);
        addr = 16'h0050;
        tick();
        chk("b2b_e1_rd", {31'd0, mem_rd[1]}, 32'd1);
        chk("b2b_e1_addr", {16'd0, mem_addr[1]}, 32'h0040);
        tick();
        chk("b2b_e2_rd", {31'd0, mem_rd[1]}, 32'd0);
        chk("b2b_e2_ack", {31'd0, ack[1]}, 32'd1);
        chk("b2b_e2_busy", {31'd0, busy[1]}, 32'd0);
        chk("b2b_e2_rdata", {16'd0, rdata[1]}, 32'h1111);
        tick();
        chk("b2b_e3_rd", {31'd0, mem_rd[1]}, 32'd1);
        chk("b2b_e3_addr", {16'd0, mem_addr[1]}, 32'h0050);
        chk("b2b_e3_ack", {31'd0, ack[1]}, 32'd0);
        req = 1'b0;
        tick();
        tick();
        chk("b2b_e5_ack", {31'd0, ack[1]}, 32'd1);
        tick();

        // Reset mid-read: abandoned with no ack, accept on first edge after release
        repeat (20) tick();
        req = 1'b1; we = 1'b0; addr = 16'h0300; mem_din = 16'h5555;
        tick();
        req = 1'b0;
        tick();
        chk("rm_e1_rd", {31'd0, mem_rd[1]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rm_async_rd", {31'd0, mem_rd[1]}, 32'd0);
        chk("rm_async_busy", {31'd0, busy[1]}, 32'd0);
        chk("rm_async_rdata", {16'd0, rdata[1]}, 32'd0);
        tick();
        chk("rm_no_ack", {31'd0, ack[1]}, 32'd0);
        chk("rm_idle", {31'd0, busy[1]}, 32'd0);
        #2;
        rst = 1'b0; req = 1'b1; addr = 16'h0077;
        tick();
        req = 1'b0;
        chk("rm_accept_rd", {31'd0, mem_rd[1]}, 32'd1);
        chk("rm_accept_addr", {16'd0, mem_addr[1]}, 32'h0077);
        tick();
        tick();
        chk("rm_accept_ack", {31'd0, ack[1]}, 32'd1);

        // LATENCY extremes
        repeat (20) tick();
        do_op(0, 1, 1'b0, 16'h0101, 16'h0000, 16'h1357);
        do_op(0, 1, 1'b1, 16'h0202, 16'h3C3C, 16'h0000);
        repeat (20) tick();
        do_op(2, 15, 1'b0, 16'h0F0F, 16'h0000, 16'h2468);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
